// File: rtl/noc_pkg.sv
// Shared NoC opcodes, length codes, FSM states and lane entry type for noc_perm_tx.
package noc_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_WRESP = 3'b100;

  localparam logic [2:0] LEN_8 = 3'b011;
  localparam logic [2:0] LEN_9 = 3'b100;

  localparam int LANES_PER_STATE = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DST,
    S_ADDR,
    S_DATA,
    S_PAR
  } state_t;

  typedef struct packed {
    logic        first;
    logic [63:0] data;
  } lane_t;

  function automatic logic [7:0] cmd_byte(input logic [2:0] len);
    return {OP_WRITE, 2'b00, len};
  endfunction
endpackage

// File: rtl/noc_skid2.sv
// Two-entry lane FIFO; stop is registered from the next occupancy so it never overflows.
module noc_skid2
  import noc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  output logic  stop,
  input  lane_t wr_lane,
  output logic  valid,
  input  logic  pop,
  output lane_t rd_lane
);
  lane_t      mem [2];
  logic       wp, rp;
  logic [1:0] cnt, cnt_nxt;
  logic       do_push, do_pop;

  assign do_push = push && !stop;
  assign do_pop  = pop && valid;
  assign valid   = (cnt != 2'd0);
  assign rd_lane = mem[rp];

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 2'd0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      stop <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      stop <= (cnt_nxt == 2'd2);
      if (do_push) wp <= ~wp;
      if (do_pop)  rp <= ~rp;
    end
  end

  // Storage needs no reset: valid gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_lane;
  end
endmodule

// File: rtl/noc_perm_tx.sv
// Frames 64-bit lanes as NoC write commands and tracks outstanding writes by credits.
// Define NOC_PERM_TX_PARITY_EN to append an XOR parity byte to every frame.
module noc_perm_tx
  import noc_pkg::*;
#(
  parameter int         MAX_OUT = 4,
  parameter logic [7:0] DEST    = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushin,
  input  logic        firstin,
  input  logic [63:0] din,
  output logic        stopin,
  output logic        tod_ctl,
  output logic [7:0]  tod_data,
  input  logic        frm_ctl,
  input  logic [7:0]  frm_data,
  output logic        err
);
`ifdef NOC_PERM_TX_PARITY_EN
  localparam logic [2:0] LEN = LEN_9;
`else
  localparam logic [2:0] LEN = LEN_8;
`endif
  localparam logic [3:0] CRED_MAX = 4'(MAX_OUT);
  localparam logic [7:0] NOP_BYTE = {OP_NOP, 5'b00000};
  localparam logic [4:0] LAST_IDX = 5'(LANES_PER_STATE - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [63:0] lane;
  logic [7:0]  addr, par;
  logic [4:0]  lane_cnt, idx;
  logic [3:0]  credits;
  logic        ctl_nxt, pop, shift, fin, start, wresp, inc;
  logic [7:0]  data_nxt;
  lane_t       wr_lane, fifo_rd;
  logic        fifo_valid;
  logic        unused_frm;

  assign wr_lane    = {firstin, din};
  assign unused_frm = ^frm_data[4:0];

  noc_skid2 u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (pushin),
    .stop    (stopin),
    .wr_lane (wr_lane),
    .valid   (fifo_valid),
    .pop     (pop),
    .rd_lane (fifo_rd)
  );

  assign wresp = frm_ctl && (frm_data[7:5] == OP_WRESP);
  assign inc   = wresp && (credits != CRED_MAX);
  assign start = fifo_valid && (credits != 4'd0);
  // firstin resynchronises the lane numbering regardless of where the counter is.
  assign idx   = fifo_rd.first ? 5'd0 : lane_cnt;

  always_comb begin
    state_nxt = state;
    ctl_nxt   = 1'b1;
    data_nxt  = NOP_BYTE;
    pop       = 1'b0;
    shift     = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: fin = 1'b1;
      S_CMD: begin
        state_nxt = S_DST;
        ctl_nxt   = 1'b0;
        data_nxt  = DEST;
      end
      S_DST: begin
        state_nxt = S_ADDR;
        ctl_nxt   = 1'b0;
        data_nxt  = addr;
      end
      S_ADDR: begin
        state_nxt = S_DATA;
        ctl_nxt   = 1'b0;
        data_nxt  = lane[7:0];
        shift     = 1'b1;
      end
      S_DATA: begin
        if (cnt != 3'd7) begin
          ctl_nxt  = 1'b0;
          data_nxt = lane[7:0];
          shift    = 1'b1;
        end else begin
`ifdef NOC_PERM_TX_PARITY_EN
          state_nxt = S_PAR;
          ctl_nxt   = 1'b0;
          data_nxt  = par;
`else
          fin = 1'b1;
`endif
        end
      end
      default: fin = 1'b1;
    endcase
    // End of a frame chains straight into the next CMD when a lane and a credit are ready.
    if (fin) begin
      state_nxt = start ? S_CMD : S_IDLE;
      if (start) begin
        ctl_nxt  = 1'b1;
        data_nxt = cmd_byte(LEN);
        pop      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      tod_ctl  <= 1'b1;
      tod_data <= NOP_BYTE;
      lane     <= 64'd0;
      addr     <= 8'h00;
      par      <= 8'h00;
      lane_cnt <= 5'd0;
      credits  <= CRED_MAX;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tod_ctl  <= ctl_nxt;
      tod_data <= data_nxt;
      cnt      <= (state == S_DATA) ? cnt + 3'd1 : 3'd0;
      if (pop) begin
        lane     <= fifo_rd.data;
        addr     <= {fifo_rd.first, 2'b00, idx};
        lane_cnt <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
        par      <= 8'h00;
      end else if (shift) begin
        lane <= {8'h00, lane[63:8]};
        par  <= par ^ lane[7:0];
      end
      if (pop && !inc)      credits <= credits - 4'd1;
      else if (inc && !pop) credits <= credits + 4'd1;
      err <= (pop && fifo_rd.first && (lane_cnt != 5'd0)) ||
             (wresp && (credits == CRED_MAX));
    end
  end
endmodule

// File: tb/tb_noc_perm_tx.sv
// Randomised bench for noc_perm_tx: byte-queue reference model plus directed literal checks.
module tb_noc_perm_tx;
  localparam int         MAX_OUT = 4;
  localparam logic [7:0] DEST    = 8'h01;
`ifdef NOC_PERM_TX_PARITY_EN
  localparam logic [7:0] HDR       = 8'h44;
  localparam int         FRAME_LEN = 12;
`else
  localparam logic [7:0] HDR       = 8'h43;
  localparam int         FRAME_LEN = 11;
`endif

  typedef struct {
    logic        first;
    logic [63:0] d;
  } ml_t;

  logic        clk = 1'b0, reset = 1'b0, pushin = 1'b0, firstin = 1'b0;
  logic [63:0] din = 64'd0;
  logic        stopin, tod_ctl, err;
  logic [7:0]  tod_data;
  logic        frm_ctl = 1'b0;
  logic [7:0]  frm_data = 8'h00;

  noc_perm_tx #(.MAX_OUT(MAX_OUT), .DEST(DEST)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .firstin(firstin), .din(din),
    .stopin(stopin), .tod_ctl(tod_ctl), .tod_data(tod_data),
    .frm_ctl(frm_ctl), .frm_data(frm_data), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: bytes still to send, lanes waiting, credits, next lane index.
  logic [8:0]  exp_q[$];
  ml_t         lq[$];
  int          m_cred = MAX_OUT, m_idx = 0, m_c0;
  logic        m_stop = 1'b0, m_err = 1'b0, m_acc, m_wr;
  logic [8:0]  m_out = 9'h100;
  ml_t         m_nl;

  int          resp_mode = 0;
  logic        force_resp = 1'b0;
  logic [7:0]  addr_log[$];
  int          mpos = 0, err_cnt = 0;
  logic [8:0]  lit[$];
  logic [7:0]  exp_full [4] = '{8'h80, 8'h01, 8'h02, 8'h03};
  logic [7:0]  exp_rs [9]   = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h80, 8'h01};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s at %0t", name, $time);
  endtask

  task automatic build(input ml_t l);
    logic [4:0] idx;
    logic [7:0] p, b;
    p = 8'h00;
    if (l.first && m_idx != 0) m_err = 1'b1;
    idx = l.first ? 5'd0 : 5'(m_idx);
    exp_q.push_back({1'b1, HDR});
    exp_q.push_back({1'b0, DEST});
    exp_q.push_back({1'b0, l.first, 2'b00, idx});
    for (int k = 0; k < 8; k++) begin
      b = l.d[8*k +: 8];
      p = p ^ b;
      exp_q.push_back({1'b0, b});
    end
    if (FRAME_LEN == 12) exp_q.push_back({1'b0, p});
    m_idx = (idx == 5'd24) ? 0 : int'(idx) + 1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      lq.delete();
      m_cred = MAX_OUT;
      m_idx  = 0;
      m_stop = 1'b0;
      m_err  = 1'b0;
      m_out  = 9'h100;
    end else begin
      m_acc    = pushin && !m_stop;
      m_nl.first = firstin;
      m_nl.d   = din;
      m_wr     = frm_ctl && (frm_data[7:5] == 3'b100);
      m_c0     = m_cred;
      m_err    = 1'b0;
      if (exp_q.size() == 0 && lq.size() > 0 && m_c0 > 0) begin
        build(lq.pop_front());
        m_cred--;
      end
      if (m_wr) begin
        if (m_c0 == MAX_OUT) m_err = 1'b1;
        else m_cred++;
      end
      m_out = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
      if (m_acc) lq.push_back(m_nl);
      m_stop = (lq.size() == 2);
    end
  end

  always @(negedge clk) begin
    chk("tod_ctl", 64'(tod_ctl), 64'(m_out[8]));
    chk("tod_data", 64'(tod_data), 64'(m_out[7:0]));
    chk("stopin", 64'(stopin), 64'(m_stop));
    chk("err", 64'(err), 64'(m_err));
    if (tod_ctl) mpos = (tod_data == HDR) ? 1 : 0;
    else if (mpos > 0) begin
      mpos++;
      if (mpos == 3) addr_log.push_back(tod_data);
    end
    if (err) err_cnt++;
  end

  always @(negedge clk) begin
    frm_ctl  = 1'b0;
    frm_data = 8'($urandom);
    if (!reset) frm_data = 8'h00;
    else if (force_resp) begin
      frm_ctl    = 1'b1;
      frm_data   = 8'h80;
      force_resp = 1'b0;
    end else if (resp_mode > 0 && m_cred < MAX_OUT && $urandom_range(0, 3) == 0) begin
      frm_ctl  = 1'b1;
      frm_data = {3'b100, 5'($urandom)};
    end else if (resp_mode == 2 && $urandom_range(0, 7) == 0) begin
      frm_ctl  = 1'b1;
      frm_data = 8'($urandom);
    end
  end

  task automatic push_lane(input logic f, input logic [63:0] d);
    int w = 0;
    while (stopin && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) timeout("push");
    pushin  = 1'b1;
    firstin = f;
    din     = d;
    @(negedge clk);
    pushin  = 1'b0;
    firstin = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((lq.size() != 0 || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) timeout("drain");
    @(negedge clk);
  endtask

  initial begin
    int w;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'(tod_ctl), 64'd1);
    chk("rst_data", 64'(tod_data), 64'h00);
    chk("rst_stop", 64'(stopin), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write response with every credit home is a protocol error.
    @(posedge clk);
    force_resp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spurious_err", 64'(err), 64'd1);
    @(negedge clk);
    chk("err_pulse_end", 64'(err), 64'd0);

    // Single lane: exact byte stream and first-byte latency.
    push_lane(1'b1, 64'h0807060504030201);
    w = 0;
    while (!(tod_ctl && tod_data == HDR) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("lat_cmd", 64'(w), 64'd1);
    lit.push_back({1'b1, HDR});
    lit.push_back({1'b0, 8'h01});
    lit.push_back({1'b0, 8'h80});
    for (int k = 0; k < 8; k++) lit.push_back({1'b0, 8'(k + 1)});
    if (FRAME_LEN == 12) lit.push_back({1'b0, 8'h08});
    lit.push_back(9'h100);
    for (int i = 0; i < lit.size(); i++) begin
      chk("single_byte", 64'({tod_ctl, tod_data}), 64'(lit[i]));
      @(negedge clk);
    end

    resp_mode = 1;
    w = 0;
    while (m_cred != MAX_OUT && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) timeout("credit_home");
    resp_mode = 0;

    // Credits run out after 4 frames; 2 more lanes fill the FIFO.
    addr_log.delete();
    err_cnt = 0;
    for (int i = 0; i < 6; i++) push_lane(i == 0, {$urandom, $urandom});
    repeat (60) @(negedge clk);
    chk("full_stop", 64'(stopin), 64'd1);
    chk("full_frames", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("full_addr", 64'(addr_log[i]), 64'(exp_full[i]));
    chk("full_err", 64'(err_cnt), 64'd1);
    resp_mode = 1;
    for (int i = 6; i < 25; i++) push_lane(1'b0, {$urandom, $urandom});
    wait_drain();

    // Resync: firstin on lane 7 restarts numbering.
    addr_log.delete();
    err_cnt = 0;
    for (int i = 0; i < 9; i++) push_lane(i == 0 || i == 7, {$urandom, $urandom});
    wait_drain();
    chk("rs_frames", 64'(addr_log.size()), 64'd9);
    for (int i = 0; i < 9 && i < addr_log.size(); i++)
      chk("rs_addr", 64'(exp_rs[i]), 64'(addr_log[i]));
    chk("rs_err", 64'(err_cnt), 64'd1);

    // Random traffic with noisy responses and a reset in the middle.
    resp_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        pushin = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
      end
      pushin  = ($urandom_range(0, 2) != 0);
      firstin = ($urandom_range(0, 19) == 0);
      din     = {$urandom, $urandom};
    end
    pushin    = 1'b0;
    firstin   = 1'b0;
    resp_mode = 1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
